// File: rtl/gj_pkg.sv
// rtl/gj_pkg.sv - shared constants and state encoding for the Gauss-Jordan inverse sequencer
package gj_pkg;
   localparam int N = 5;
   localparam int W = 32;

   localparam logic [4:0] ROM_BASE   = 5'd1;
   localparam logic [4:0] LOAD_WORDS = 5'(N * N);
   localparam logic [2:0] K_LAST     = 3'(N - 1);
   localparam logic [2:0] R_LAST     = 3'(N - 2);
   localparam logic [2:0] COL_MAX    = 3'(N - 1);
   localparam logic [3:0] C_LAST     = 4'(2 * N - 1);
   localparam logic [3:0] N4         = 4'(N);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      LATCH,
      ELIM,
      CHECK,
      DONE
   } state_t;
endpackage

// File: rtl/gj_index_walker.sv
// rtl/gj_index_walker.sv - nested pivot/target/column counter that skips the diagonal row
module gj_index_walker
   import gj_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       init,
   input  logic       step,
   output logic [2:0] k,
   output logic [2:0] r,
   output logic [3:0] c,
   output logic       col_last,
   output logic       last
);

   logic [3:0] nr;

   // Next target row, stepping over the pivot row itself.
   always_comb begin
      nr = {1'b0, r} + 4'd1;
      if (nr == {1'b0, k}) begin
         nr = nr + 4'd1;
      end
   end

   assign col_last = (c == C_LAST);
   assign last     = col_last && (k == K_LAST) && (r == R_LAST);

   always_ff @(posedge clk) begin
      if (!reset) begin
         k <= '0;
         r <= '0;
         c <= '0;
      end else if (init) begin
         k <= '0;
         r <= 3'd1;
         c <= '0;
      end else if (step) begin
         if (col_last) begin
            c <= '0;
            if (nr >= N4) begin
               k <= k + 3'd1;
               r <= '0;
            end else begin
               r <= nr[2:0];
            end
         end else begin
            c <= c + 4'd1;
         end
      end
   end

endmodule

// File: rtl/gj_inverse_sequencer.sv
// rtl/gj_inverse_sequencer.sv - load, elimination command stream and singular check for the 5x5 inverse
module gj_inverse_sequencer
   import gj_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   output logic [4:0]   rom_addr,
   input  logic [W-1:0] rom_data,
   output logic         id_init,
   output logic         ld_we,
   output logic [2:0]   ld_row,
   output logic [2:0]   ld_col,
   output logic [W-1:0] ld_data,
   output logic         op_valid,
   input  logic         op_ready,
   output logic         op_latch,
   output logic [2:0]   op_pivot,
   output logic [2:0]   op_target,
   output logic [3:0]   op_col,
   input  logic [N-1:0] diag_zero,
   output logic         busy,
   output logic         done,
   output logic         singular
);

   state_t     state, state_n;
   logic [4:0] load_cnt;
   logic [2:0] ld_row_q, ld_col_q;
   logic       walk_init, walk_step;
   logic [2:0] wk, wr;
   logic [3:0] wc;
   logic       col_last, last;

   gj_index_walker u_walker (
      .clk      (clk),
      .reset    (reset),
      .init     (walk_init),
      .step     (walk_step),
      .k        (wk),
      .r        (wr),
      .c        (wc),
      .col_last (col_last),
      .last     (last)
   );

   always_comb begin
      state_n   = state;
      rom_addr  = '0;
      ld_we     = 1'b0;
      id_init   = 1'b0;
      op_valid  = 1'b0;
      op_latch  = 1'b0;
      walk_init = 1'b0;
      walk_step = 1'b0;
      done      = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (start) state_n = LOAD;
         end
         LOAD: begin
            // Address leads the write by one cycle to cover the ROM read latency.
            id_init = (load_cnt == 5'd0);
            if (load_cnt < LOAD_WORDS) rom_addr = load_cnt + ROM_BASE;
            if (load_cnt != 5'd0) ld_we = 1'b1;
            if (load_cnt == LOAD_WORDS) begin
               state_n   = LATCH;
               walk_init = 1'b1;
            end
         end
         LATCH: begin
            op_valid = 1'b1;
            op_latch = 1'b1;
            if (op_ready) state_n = ELIM;
         end
         ELIM: begin
            op_valid = 1'b1;
            if (op_ready) begin
               walk_step = 1'b1;
               if (col_last) state_n = last ? CHECK : LATCH;
            end
         end
         CHECK: state_n = DONE;
         DONE: begin
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign op_pivot  = op_valid ? wk : 3'd0;
   assign op_target = op_valid ? wr : 3'd0;
   assign op_col    = (state == ELIM) ? wc : 4'd0;
   assign ld_row    = ld_we ? ld_row_q : 3'd0;
   assign ld_col    = ld_we ? ld_col_q : 3'd0;
   assign ld_data   = ld_we ? rom_data : '0;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         load_cnt <= '0;
         ld_row_q <= '0;
         ld_col_q <= '0;
         singular <= 1'b0;
      end else begin
         state    <= state_n;
         load_cnt <= (state == LOAD) ? load_cnt + 5'd1 : 5'd0;
         if (state == IDLE) begin
            ld_row_q <= '0;
            ld_col_q <= '0;
         end else if (ld_we) begin
            if (ld_col_q == COL_MAX) begin
               ld_col_q <= '0;
               ld_row_q <= ld_row_q + 3'd1;
            end else begin
               ld_col_q <= ld_col_q + 3'd1;
            end
         end
         if (state == IDLE && start) singular <= 1'b0;
         else if (state == CHECK) singular <= |diag_zero;
      end
   end

endmodule

// File: tb/tb_gj_inverse_sequencer.sv
// tb/tb_gj_inverse_sequencer.sv - self-checking bench for gj_inverse_sequencer
module tb_gj_inverse_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [4:0]  rom_addr;
   logic [31:0] rom_data = 32'd0;
   logic        id_init;
   logic        ld_we;
   logic [2:0]  ld_row, ld_col;
   logic [31:0] ld_data;
   logic        op_valid;
   logic        op_ready;
   logic        op_latch;
   logic [2:0]  op_pivot, op_target;
   logic [3:0]  op_col;
   logic [4:0]  diag_zero;
   logic        busy, done, singular;

   gj_inverse_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .id_init   (id_init),
      .ld_we     (ld_we),
      .ld_row    (ld_row),
      .ld_col    (ld_col),
      .ld_data   (ld_data),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .op_latch  (op_latch),
      .op_pivot  (op_pivot),
      .op_target (op_target),
      .op_col    (op_col),
      .diag_zero (diag_zero),
      .busy      (busy),
      .done      (done),
      .singular  (singular)
   );

   always #5 clk = ~clk;

   // ROM with one-cycle read latency, word a = 100 + a
   always @(posedge clk) rom_data <= 32'd100 + 32'(rom_addr);

   typedef struct packed {
      logic       latch;
      logic [2:0] k;
      logic [2:0] r;
      logic [3:0] c;
   } cmd_t;

   typedef struct {
      int   idx;
      cmd_t cmd;
   } cmd_vec_t;

   typedef struct {
      int          idx;
      logic [2:0]  row;
      logic [2:0]  col;
      logic [31:0] data;
   } ld_vec_t;

   cmd_t    exp_q[$];
   cmd_t    log_cmd[$];
   ld_vec_t log_ld[$];
   int      errors = 0;
   int      checks = 0;

   task automatic check_eq(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input bit random_ready, input logic [4:0] dz, input bit exp_sing,
                      input bit abort_k2, input bit chk_tables);
      int   cyc, stalls, id_cnt, id_cyc, first_ld, done_cyc, busy_bad;
      bit   prev_stall;
      cmd_t prev, cur, e;
      cmd_vec_t cmd_tab[5];
      ld_vec_t  ld_tab[3];

      cmd_tab[0] = '{0,   '{1'b1, 3'd0, 3'd1, 4'd0}};
      cmd_tab[1] = '{1,   '{1'b0, 3'd0, 3'd1, 4'd0}};
      cmd_tab[2] = '{10,  '{1'b0, 3'd0, 3'd1, 4'd9}};
      cmd_tab[3] = '{11,  '{1'b1, 3'd0, 3'd2, 4'd0}};
      cmd_tab[4] = '{219, '{1'b0, 3'd4, 3'd3, 4'd9}};
      ld_tab[0]  = '{0,  3'd0, 3'd0, 32'd101};
      ld_tab[1]  = '{7,  3'd1, 3'd2, 32'd108};
      ld_tab[2]  = '{24, 3'd4, 3'd4, 32'd125};

      exp_q.delete();
      log_cmd.delete();
      log_ld.delete();
      for (int k = 0; k < 5; k++)
         for (int r = 0; r < 5; r++)
            if (r != k) begin
               exp_q.push_back('{1'b1, 3'(k), 3'(r), 4'd0});
               for (int c = 0; c < 10; c++) exp_q.push_back('{1'b0, 3'(k), 3'(r), 4'(c)});
            end

      stalls = 0; id_cnt = 0; id_cyc = -1; first_ld = -1; done_cyc = -1; busy_bad = 0;
      prev_stall = 1'b0; prev = '0;
      diag_zero = dz;
      op_ready = 1'b0;
      start = 1'b1;
      tick;
      start = 1'b0;
      cyc = 1;
      check_eq("singular_cleared_on_start", singular, 0);

      while (cyc <= 2000) begin
         op_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (random_ready) start = 1'($urandom_range(0, 1));
         if (!busy) busy_bad++;
         if (id_init) begin
            id_cnt++;
            id_cyc = cyc;
         end
         if (ld_we) begin
            if (first_ld < 0) first_ld = cyc;
            log_ld.push_back('{log_ld.size(), ld_row, ld_col, ld_data});
         end
         if (op_valid) begin
            cur = '{op_latch, op_pivot, op_target, op_col};
            if (prev_stall) check_eq("stall_fields_stable", cur, prev);
         end
         if (abort_k2 && op_valid && !op_latch && op_pivot == 3'd2) begin
            reset = 1'b0;
            start = 1'b0;
            tick;
            check_eq("abort_busy", busy, 0);
            check_eq("abort_op_valid", op_valid, 0);
            check_eq("abort_done", done, 0);
            reset = 1'b1;
            tick;
            return;
         end
         if (op_valid && op_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("extra_transfer", log_cmd.size(), 220);
            end else begin
               e = exp_q.pop_front();
               if (cur.latch) begin
                  cur.c = 4'd0;
                  e.c   = 4'd0;
               end
               check_eq("transfer_cmd", cur, e);
            end
            log_cmd.push_back(cur);
            prev_stall = 1'b0;
         end else if (op_valid) begin
            stalls++;
            prev_stall = 1'b1;
            prev = cur;
         end else begin
            prev_stall = 1'b0;
         end
         if (done) begin
            done_cyc = cyc;
            break;
         end
         tick;
         cyc++;
      end

      check_eq("done_cycle", done_cyc, 248 + stalls);
      check_eq("busy_while_running", busy_bad, 0);
      check_eq("remaining_expected", exp_q.size(), 0);
      check_eq("singular_at_done", singular, exp_sing);

      start = 1'b1;
      tick;
      check_eq("start_with_done_ignored", busy, 0);
      start = 1'b0;
      repeat (3) tick;
      check_eq("idle_after_done", busy, 0);
      check_eq("singular_held", singular, exp_sing);

      if (chk_tables) begin
         check_eq("id_init_count", id_cnt, 1);
         check_eq("id_init_before_load", (id_cyc >= 0 && id_cyc < first_ld), 1);
         check_eq("load_pulse_count", log_ld.size(), 25);
         foreach (ld_tab[i]) begin
            if (log_ld.size() > ld_tab[i].idx) begin
               check_eq("load_row", log_ld[ld_tab[i].idx].row, ld_tab[i].row);
               check_eq("load_col", log_ld[ld_tab[i].idx].col, ld_tab[i].col);
               check_eq("load_data", log_ld[ld_tab[i].idx].data, ld_tab[i].data);
            end else begin
               check_eq("load_pulse_missing", log_ld.size(), ld_tab[i].idx + 1);
            end
         end
         foreach (cmd_tab[i]) begin
            if (log_cmd.size() > cmd_tab[i].idx) begin
               cur = log_cmd[cmd_tab[i].idx];
               e   = cmd_tab[i].cmd;
               check_eq("table_cmd", cur, e);
            end else begin
               check_eq("table_cmd_missing", log_cmd.size(), cmd_tab[i].idx + 1);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      op_ready = 1'b0;
      diag_zero = 5'd0;
      repeat (2) tick;
      check_eq("reset_busy", busy, 0);
      check_eq("reset_done", done, 0);
      check_eq("reset_op_valid", op_valid, 0);
      check_eq("reset_singular", singular, 0);
      check_eq("reset_rom_addr", rom_addr, 0);
      check_eq("reset_ld_we", ld_we, 0);
      check_eq("reset_id_init", id_init, 0);
      reset = 1'b1;
      tick;

      run(1'b0, 5'b00100, 1'b1, 1'b0, 1'b1);
      run(1'b1, 5'b00000, 1'b0, 1'b0, 1'b0);
      run(1'b0, 5'b00000, 1'b0, 1'b1, 1'b0);
      run(1'b0, 5'b00000, 1'b0, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gj_inverse_sequencer.md
# gj_inverse_sequencer

Control sequencer for the 5×5 Gauss-Jordan integer inverse datapath. It loads the coefficient matrix from the coefficient ROM and initialises the identity augment. It then issues the pivot/row/column elimination command stream to a shared single-lane cross-multiply-subtract unit. Finally it samples the diagonal to flag singular matrices. It sits between the ROM, the matrix/augment register file, and the row-operation unit, and replaces the fully unrolled single-cycle elimination.

## Interface
- N, 5, matrix order.
- W, 32, element width in bits.
- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- start  in  1  begin inversion; sampled only in IDLE.
- rom_addr  out  5  ROM read address.
- rom_data  in  W  ROM word; valid one cycle after rom_addr.
- id_init  out  1  one-cycle pulse: register file writes identity into the augment.
- ld_we  out  1  load write strobe.
- ld_row, ld_col  out  3, 3  load destination indices.
- ld_data  out  W  load data; rom_data passed through.
- op_valid  out  1  command valid.
- op_ready  in  1  datapath accepts the command.
- op_latch  out  1  1 = latch x=a[k][k], y=a[r][k]; 0 = eliminate one column.
- op_pivot  out  3  pivot row k.
- op_target  out  3  target row r.
- op_col  out  4  column, 0..2N-1; values ≥N address the augment.
- diag_zero  in  N  per-diagonal zero flags from the datapath.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- singular  out  1  result flag; holds until the next accepted start.

## Operation
- Reset: the following outputs are 0 and the block enters IDLE.
  - rom_addr, ld_*, op_*, id_init, busy, done, singular.
  - Reset mid-run aborts without completion.
- States: IDLE → LOAD → LATCH → ELIM → (LATCH | CHECK) → DONE → IDLE.
- IDLE:
  - start=1 moves to LOAD and clears singular.
  - start is ignored while busy.
- LOAD:
  - id_init is high in the first LOAD cycle.
  - Load cycle i (0..N²-1) drives rom_addr=i+1; ROM word 0 is unused.
  - Cycle i+1 asserts ld_we with ld_row=i/N, ld_col=i%N.
  - After the last write, go to LATCH with k=0, r=1.
- Command stream:
  - Pivot k=0..N-1; target r=0..N-1, skipping r=k.
  - For each (k,r): one LATCH command, then ELIM for c=0..2N-1.
  - Datapath function: t[c] = x·t[c] − y·p[c], mod 2^W.
- Handshake:
  - op_valid and all op_* fields stay stable until a cycle with op_valid & op_ready.
  - Advance only on that transfer.
  - op_ready while op_valid=0 has no effect.
- After the final ELIM (k=N-1, r=N-2, c=2N-1) transfers, go to CHECK.
- CHECK: singular = |diag_zero, sampled in this one cycle; no op_valid.
- DONE: done=1, busy=1 for one cycle, then IDLE.

## Timing
- Load phase: N²+1 = 26 cycles (address/write pipeline).
- Commands: N(N−1)(2N+1) = 220 transfers; each transfer costs ≥1 cycle.
- With op_ready tied high, start accepted at edge T gives:
  - done high in cycle T+248;
  - busy high from T+1 through T+248.
- op_ready stall of s cycles on any command delays done by exactly s.
- No command is skipped or repeated across a stall.
- start asserted in the same cycle as done is ignored; re-start needs IDLE.

## Structure
- Shared package gj_pkg holds:
  - state enum (IDLE, LOAD, LATCH, ELIM, CHECK, DONE);
  - N, W, and the ROM base offset (1).
- One natural sub-module: gj_index_walker, the nested k/r/c counter with diagonal skip and a last flag.
- The FSM and load pipeline stay in the top level.

## Test plan
- Reset during ELIM at k=2:
  - next edge gives busy=0, op_valid=0, done=0;
  - a fresh start completes in 248 cycles.
- Load check, op_ready=1, ROM word a = 100+a:
  - exactly 25 ld_we pulses, with id_init pulsed once first;
  - pulse 7 carries row 1, col 2, data 108.
- Command order with op_ready=1:
  - transfer 0 = latch(k0,r1), transfers 1..10 = ELIM c0..9;
  - transfer 11 = latch(k0,r2);
  - transfer 219 = ELIM(k4,r3,c9); done at T+248.
- Random op_ready (50%):
  - the transfer sequence matches the op_ready=1 run exactly;
  - done is delayed by exactly the count of stalled cycles.
- Singular flag:
  - diag_zero=5'b00100 in CHECK gives singular=1 at done, held until the next start;
  - diag_zero=0 gives singular=0.
- start pulses while busy have no effect; start coincident with done is ignored.
